vr_regfile_slave: RTL and testbench

- Parametrised next-generation slave for the valid/addr/wdata/rdata/ready point-to-point bus.
- Adds the following to the fixed combinational slave:
  - write/read distinction;
  - a DEPTH-entry register file;
  - programmable wait states;
  - a registered single-cycle ready pulse;
  - a transaction counter.
- Sits between a bus master and local control/status logic inside a subsystem.

---
 rtl/vr_regfile_slave.sv | 142 ++++++++++++++
 tb/tb_vr_regfile_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vr_regfile_slave.sv
// Register-file slave for the valid/ready bus; optional VR_SLAVE_ERR_EN adds err/err_cnt.
// Latency WAIT_CYCLES+1 from capture to a one-cycle ready pulse; valid is ignored while busy.
module vr_regfile_slave #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_cnt
`ifdef VR_SLAVE_ERR_EN
  ,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef VR_SLAVE_ERR_EN
  localparam logic [DATA_W-1:0] OOR_RD = '1;
`else
  localparam logic [DATA_W-1:0] OOR_RD = '0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                capture, enter_resp;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          wait_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  // When answering straight from IDLE the request is still on the bus, not yet in the _q regs.
  logic [ADDR_W-1:0]   req_addr;
  logic                req_we;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_ok;
  logic [DATA_W-1:0]   resp_dat;
  logic                addr_ok_q;
  logic                wr_en;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_addr  = capture ? addr  : addr_q;
    req_we    = capture ? we    : we_q;
    req_wdata = capture ? wdata : wdata_q;
    req_ok    = {1'b0, req_addr} < DEPTH_L;
    resp_dat  = OOR_RD;
    if (req_we)      resp_dat = req_wdata;
    else if (req_ok) resp_dat = mem[req_addr[IDX_W-1:0]];
  end

  assign addr_ok_q = {1'b0, addr_q} < DEPTH_L;
  assign wr_en     = (state == RESP) && we_q && addr_ok_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      txn_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef VR_SLAVE_ERR_EN
      err      <= 1'b0;
      err_cnt  <= '0;
`endif
    end else begin
      if (capture) begin
        addr_q   <= addr;
        we_q     <= we;
        wdata_q  <= wdata;
        wait_cnt <= WAIT_INIT;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (capture)             busy <= 1'b1;
      else if (state == RESP)  busy <= 1'b0;

      ready <= enter_resp;
      if (enter_resp) rdata <= resp_dat;

      // Commit happens on the edge leaving RESP so a reset on that edge cancels the write.
      if (state == RESP) txn_cnt <= txn_cnt + 1'b1;
      if (wr_en) mem[addr_q[IDX_W-1:0]] <= wdata_q;

`ifdef VR_SLAVE_ERR_EN
      err <= enter_resp && !req_ok;
      if (state == RESP && err) err_cnt <= err_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_vr_regfile_slave.sv
// Scoreboard bench: three slave instances (WAIT 0/3/2, dut2 with CNT_W=2) driven one at a time.
module tb_vr_regfile_slave;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]      reset;
  logic [2:0]      valid;
  logic [2:0]      we;
  logic [2:0][3:0] addr;
  logic [2:0][3:0] wdata;
  wire  [2:0][3:0] rdata;
  wire  [2:0]      ready;
  wire  [2:0]      busy;
  wire  [2:0][7:0] cnt;
  assign cnt[2][7:2] = 6'd0;
`ifdef VR_SLAVE_ERR_EN
  wire  [2:0]      err;
  wire  [2:0][7:0] err_cnt;
  assign err_cnt[2][7:2] = 6'd0;
  localparam logic [3:0] OOR_RD = 4'hF;
`else
  localparam logic [3:0] OOR_RD = 4'h0;
`endif

  vr_regfile_slave #(.WAIT_CYCLES(0), .CNT_W(8)) dut0 (
    .clock(clock), .reset(reset[0]), .valid(valid[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .txn_cnt(cnt[0])
`ifdef VR_SLAVE_ERR_EN
    , .err(err[0]), .err_cnt(err_cnt[0])
`endif
  );
  vr_regfile_slave #(.WAIT_CYCLES(3), .CNT_W(8)) dut1 (
    .clock(clock), .reset(reset[1]), .valid(valid[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .txn_cnt(cnt[1])
`ifdef VR_SLAVE_ERR_EN
    , .err(err[1]), .err_cnt(err_cnt[1])
`endif
  );
  vr_regfile_slave #(.WAIT_CYCLES(2), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset[2]), .valid(valid[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .busy(busy[2]), .txn_cnt(cnt[2][1:0])
`ifdef VR_SLAVE_ERR_EN
    , .err(err[2]), .err_cnt(err_cnt[2][1:0])
`endif
  );

  typedef struct {
    int         d;
    logic [3:0] rd;
    logic       e;
    logic [7:0] c;
    logic [7:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: compare the response in the ready cycle, counters one cycle later.
  logic pend = 1'b0;
  exp_t pend_e;
  always @(negedge clock) begin
    if (pend) begin
      checks++;
      if (cnt[pend_e.d] !== pend_e.c || busy[pend_e.d] !== 1'b0) begin
        errors++;
        $display("FAIL post_resp dut%0d: txn_cnt=%0d busy=%b, expected txn_cnt=%0d busy=0",
                 pend_e.d, cnt[pend_e.d], busy[pend_e.d], pend_e.c);
      end
`ifdef VR_SLAVE_ERR_EN
      checks++;
      if (err_cnt[pend_e.d] !== pend_e.ec) begin
        errors++;
        $display("FAIL err_cnt dut%0d: got %0d expected %0d", pend_e.d, err_cnt[pend_e.d], pend_e.ec);
      end
`endif
      pend = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      if (ready[d] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready dut%0d: ready=1 with nothing outstanding, expected ready=0", d);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.d != d || rdata[d] !== e.rd) begin
            errors++;
            $display("FAIL rdata dut%0d: got 0x%h, expected dut%0d 0x%h", d, rdata[d], e.d, e.rd);
          end
`ifdef VR_SLAVE_ERR_EN
          checks++;
          if (err[d] !== e.e) begin
            errors++;
            $display("FAIL err dut%0d: got %b expected %b", d, err[d], e.e);
          end
`endif
          pend_e = e;
          pend   = 1'b1;
        end
      end
    end
  end

  task automatic txn(input int d, input logic w, input logic [3:0] a, input logic [3:0] wd,
                     input logic [3:0] erd, input logic ee, input logic [7:0] ec,
                     input logic [7:0] eec, input int elat);
    int lat, bcnt;
    bit got;
    exp_q.push_back('{d: d, rd: erd, e: ee, c: ec, ec: eec});
    @(posedge clock); #1;
    valid[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    lat = 0; bcnt = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (busy[d] === 1'b1) bcnt++;
      if (ready[d] === 1'b1) got = 1'b1;
    end
    valid[d] = 1'b0;
    checks++;
    if (!got || lat != elat) begin
      errors++;
      $display("FAIL latency dut%0d addr=%0d: got %0d cycles (ready seen=%b), expected %0d", d, a, lat, got, elat);
    end
    checks++;
    if (bcnt != elat) begin
      errors++;
      $display("FAIL busy_len dut%0d addr=%0d: busy high %0d cycles, expected %0d", d, a, bcnt, elat);
    end
  endtask

  initial begin
    reset = 3'b111; valid = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clock);
    #1 reset = 3'b000;

    // Idle after reset: everything stays quiet.
    repeat (5) begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (ready[d] !== 1'b0 || busy[d] !== 1'b0 || rdata[d] !== 4'h0 || cnt[d] !== 8'd0) begin
          errors++;
          $display("FAIL reset_idle dut%0d: ready=%b busy=%b rdata=0x%h txn_cnt=%0d, expected all 0",
                   d, ready[d], busy[d], rdata[d], cnt[d]);
        end
      end
    end

    // dut0: zero wait states, DEPTH=8
    txn(0, 1'b1, 4'd3,  4'hC, 4'hC,   1'b0, 8'd1, 8'd0, 1);
    txn(0, 1'b0, 4'd3,  4'h0, 4'hC,   1'b0, 8'd2, 8'd0, 1);
    txn(0, 1'b1, 4'd0,  4'h5, 4'h5,   1'b0, 8'd3, 8'd0, 1);
    txn(0, 1'b0, 4'd9,  4'h0, OOR_RD, 1'b1, 8'd4, 8'd1, 1);
    txn(0, 1'b0, 4'd3,  4'h0, 4'hC,   1'b0, 8'd5, 8'd1, 1);
    txn(0, 1'b1, 4'd10, 4'hA, 4'hA,   1'b1, 8'd6, 8'd2, 1);
    txn(0, 1'b0, 4'd2,  4'h0, 4'h0,   1'b0, 8'd7, 8'd2, 1);
    txn(0, 1'b0, 4'd0,  4'h0, 4'h5,   1'b0, 8'd8, 8'd2, 1);

    // dut1: three wait states
    txn(1, 1'b1, 4'd5, 4'h9, 4'h9, 1'b0, 8'd1, 8'd0, 4);
    txn(1, 1'b0, 4'd5, 4'h0, 4'h9, 1'b0, 8'd2, 8'd0, 4);

    // dut2: write cancelled by a reset while waiting
    @(posedge clock); #1;
    valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 4'd1; wdata[2] = 4'h7;
    @(posedge clock);
    @(posedge clock); #1;
    reset[2] = 1'b1; valid[2] = 1'b0;
    @(posedge clock); #1;
    reset[2] = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (ready[2] !== 1'b0 || busy[2] !== 1'b0 || cnt[2] !== 8'd0) begin
        errors++;
        $display("FAIL reset_in_wait: ready=%b busy=%b txn_cnt=%0d, expected 0 0 0", ready[2], busy[2], cnt[2]);
      end
    end

    // dut2: five reads with a 2-bit counter (wraps 3 -> 0)
    txn(2, 1'b0, 4'd1, 4'h0, 4'h0, 1'b0, 8'd1, 8'd0, 3);
    txn(2, 1'b0, 4'd1, 4'h0, 4'h0, 1'b0, 8'd2, 8'd0, 3);
    txn(2, 1'b0, 4'd0, 4'h0, 4'h0, 1'b0, 8'd3, 8'd0, 3);
    txn(2, 1'b0, 4'd7, 4'h0, 4'h0, 1'b0, 8'd0, 8'd0, 3);
    txn(2, 1'b0, 4'd1, 4'h0, 4'h0, 1'b0, 8'd1, 8'd0, 3);

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
